// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the combinational ALU: FIFO-buffered commands, one ALU cycle each, registered response.
// Latency: command accepted at edge T into an idle, empty block -> ISSUE in cycle T+1 -> rsp_valid at edge T+2.
// Backpressure: cmd_ready drops when the FIFO is full; no new issue while a response waits on rsp_ready.
// Optional result flags (rsp_zero/rsp_neg) are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [W-1:0]               cmd_a,
    input  logic [W-1:0]               cmd_b,
    output logic                       alu_en,
    output logic [2:0]                 alu_op,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    input  logic [W-1:0]               alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [W-1:0]               rsp_data,
    output logic                       rsp_zero,
    output logic                       rsp_neg,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    fifo_op [DEPTH];
    logic [W-1:0]  fifo_a  [DEPTH];
    logic [W-1:0]  fifo_b  [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, fifo_empty;

    assign cmd_ready  = (occupancy < FULL_CNT);
    assign fifo_empty = (occupancy == '0);
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == ISSUE);

    // Storage needs no reset: entries are only ever read behind a valid occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr] <= cmd_op;
            fifo_a[wr_ptr]  <= cmd_a;
            fifo_b[wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        alu_en    = 1'b0;
        alu_op    = '0;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !rsp_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                alu_en    = 1'b1;
                alu_op    = fifo_op[rd_ptr];
                alu_a     = fifo_a[rd_ptr];
                alu_b     = fifo_b[rd_ptr];
                state_nxt = HOLD;
            end
            HOLD: begin
                if (rsp_ready) state_nxt = fifo_empty ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // alu_result is only sampled on the edge that ends ISSUE, when the ALU is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (state == ISSUE) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
        end else if (state == HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
        end else if (state == ISSUE) begin
            rsp_zero <= (alu_result == '0);
            rsp_neg  <= alu_result[W-1];
        end
    end
`else
    assign rsp_zero = 1'b0;
    assign rsp_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, scoreboard queue of expected responses, negedge monitor.
module tb_alu_cmd_sequencer;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_a, cmd_b;
    logic          alu_en;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_zero, rsp_neg;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
        .occupancy(occupancy)
    );

    function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a + 1;
            3'b011:  return a - 1;
            3'b100:  return a;
            3'b101:  return ~a;
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_result = alu_en ? alu_f(alu_op, alu_a, alu_b) : 'x;

    typedef struct packed {
        logic [W-1:0] d;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: scoreboard pops, hold stability, issue spacing, streaming gap
    int           cyc = 0;
    int           issues = 0;
    int           last_pop = -1;
    bit           gap_chk = 1'b0;
    logic         prev_en = 1'b0, prev_hold = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_z, prev_n;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_en   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (alu_en) begin
                issues++;
                chk("b2b_issue", prev_en, 1'b0);
            end
            if (prev_hold) begin
                chk("hold_valid", rsp_valid, 1'b1);
                chk("hold_data", rsp_data, prev_data);
                chk("hold_zero", rsp_zero, prev_z);
                chk("hold_neg", rsp_neg, prev_n);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    e_m = sb.pop_front();
                    chk("rsp_data", rsp_data, e_m.d);
                    chk("rsp_zero", rsp_zero, e_m.z);
                    chk("rsp_neg", rsp_neg, e_m.n);
                end
                if (gap_chk && last_pop >= 0) chk("stream_gap", cyc - last_pop, 2);
                last_pop = cyc;
            end
            prev_en   = alu_en;
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_z    = rsp_zero;
            prev_n    = rsp_neg;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        bit acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (acc) begin
            r = alu_f(op, a, b);
`ifdef ALU_SEQ_FLAGS_EN
            sb.push_back({r, (r == '0), r[W-1]});
`else
            sb.push_back({r, 1'b0, 1'b0});
`endif
        end else begin
            chk("send_timeout", 1'b0, 1'b1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rsp_valid && occupancy == '0) break;
        end
        chk("drain_sb", sb.size(), 0);
        chk("drain_occ", occupancy, 0);
        @(posedge clk);
        #1;
    endtask

    int  snap;
    bit  seen;

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_alu_en", alu_en, 1'b0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_flags", {rsp_zero, rsp_neg}, 0);
        chk("rst_occ", occupancy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single command latency
        send(3'b000, 5, 7);
        @(negedge clk);
        chk("lat_idle_en", alu_en, 1'b0);
        @(negedge clk);
        chk("lat_issue_en", alu_en, 1'b1);
        chk("lat_issue_op", alu_op, 3'b000);
        chk("lat_issue_a", alu_a, 5);
        chk("lat_issue_b", alu_b, 7);
        @(negedge clk);
        chk("lat_after_en", alu_en, 1'b0);
        chk("lat_rsp_valid", rsp_valid, 1'b1);
        chk("lat_rsp_data", rsp_data, 12);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();

        // Wraparound and flags
        send(3'b001, 0, 1);
        send(3'b111, 32'h0000_00F0, 32'h0000_000F);
        drain();

        // Fill with response held, then backpressure hold
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(3'b000, i, 100);
        @(negedge clk);
        chk("fill_occ", occupancy, DEPTH);
        chk("fill_cmd_ready", cmd_ready, 1'b0);
        chk("fill_rsp_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_alu_en", alu_en, 1'b0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();

        // Streaming
        last_pop = -1;
        gap_chk = 1'b1;
        for (int i = 0; i < 8; i++) send(3'b010, i, 0);
        drain();
        gap_chk = 1'b0;

        // Reset during ISSUE with entries queued
        rsp_ready = 1'b0;
        send(3'b000, 1, 1);
        for (int i = 0; i < 3; i++) send(3'b101, i, 0);
        @(negedge clk);
        chk("pre_rst_occ", occupancy, 3);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = alu_en;
        end
        chk("rst_issue_seen", seen, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_en", alu_en, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_rsp_data", rsp_data, 0);
        sb.delete();
        snap = issues;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_occ", occupancy, 0);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk("post_rst_no_issue", issues, snap);
        @(posedge clk);
        #1;
        send(3'b100, 32'h0000_ABCD, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 32-bit combinational ALU.
- Accepts ALU commands (opcode, A, B) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's operand, opcode and enable inputs for exactly one cycle per command, registers the ALU result, and presents it downstream over a second valid/ready handshake.
- Keeps ALU enable low whenever no command is issuing, so the ALU output floats.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- W, 32, operand/result width; must match the ALU width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  3  ALU opcode: 000 add, 001 sub, 010 inc A, 011 dec A, 100 pass A, 101 not A, 110 or, 111 and.
- cmd_a  in  W  operand A.
- cmd_b  in  W  operand B.
- alu_en  out  1  ALU enable.
- alu_op  out  3  ALU opcode.
- alu_a  out  W  ALU operand A.
- alu_b  out  W  ALU operand B.
- alu_result  in  W  ALU result, combinational from alu_* outputs.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  downstream accepts response.
- rsp_data  out  W  captured result.
- rsp_zero  out  1  flag: result == 0 (optional feature).
- rsp_neg  out  1  flag: result[W-1] (optional feature).
- occupancy  out  log2(DEPTH)+1  FIFO entry count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: cmd_ready=1, alu_en=0, alu_op=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_neg=0, occupancy=0. FSM state is IDLE and FIFO pointers are 0.
- cmd_ready is combinational: occupancy < DEPTH. There is no write-through when full, so a push on a full FIFO is impossible by construction.
- Push occurs when cmd_valid && cmd_ready. A push and a pop in the same cycle leave occupancy unchanged.
- Pointers wrap modulo DEPTH; occupancy is tracked separately to distinguish full from empty.
- FSM states:
  - IDLE: alu_en=0. If the FIFO is non-empty and rsp_valid=0, go to ISSUE.
  - ISSUE: alu_en=1 and alu_op/alu_a/alu_b are driven from the FIFO head, all combinational from the head entry. At the clock edge ending ISSUE:
    - alu_result is captured into rsp_data and rsp_valid is set.
    - The head is popped.
    - Next state is HOLD.
  - HOLD: alu_en=0. rsp_valid is held until rsp_ready=1, then rsp_valid clears.
    - If the FIFO is non-empty after that handshake, go to ISSUE; otherwise go to IDLE.
    - When rsp_valid && rsp_ready and the FIFO is non-empty, HOLD goes directly to ISSUE on the next cycle.
- Latency: a command accepted at edge T into an empty FIFO with the FSM in IDLE gives ISSUE during cycle T+1 and rsp_valid at edge T+2.
- Throughput: one command per 2 cycles when rsp_ready is held at 1.
- Ordering: responses leave in command order. No command is dropped or duplicated.
- rsp_data and the flags are stable while rsp_valid=1 && rsp_ready=0.
- Arithmetic wraps modulo 2^W, as produced by the ALU. The block performs no arithmetic itself.
- An X or Z value on alu_result outside ISSUE is never sampled.
- Reset mid-operation (any state): the FIFO is flushed, the in-flight response is discarded, and all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN.
- Defined: at the ISSUE capture edge, rsp_zero = (alu_result == 0) and rsp_neg = alu_result[W-1]. Both are registered alongside rsp_data.
- Undefined: rsp_zero and rsp_neg are tied to 0 and no flag registers exist. The port list is unchanged.

Test Plan:
- Reset then single command: push op=000, A=5, B=7 -> alu_en high for exactly 1 cycle with alu_a=5, alu_b=7; rsp_valid at T+2 with rsp_data=12; with flags, zero=0 and neg=0.
- Wrap and flags: op=001, A=0, B=1 -> rsp_data=0xFFFFFFFF, neg=1. Then op=111, A=0xF0, B=0x0F -> rsp_data=0, zero=1.
- Fill: push 5 back-to-back commands with rsp_ready=0 -> cmd_ready drops after the FIFO is full with occupancy=4 and one response held. Raise rsp_ready -> all 5 results emerge in order.
- Backpressure hold: rsp_ready=0 for 10 cycles -> rsp_data stable, alu_en=0 throughout, no second issue.
- Streaming: rsp_ready=1 with 8 queued commands op=010, A=i -> results i+1 in order, one every 2 cycles, alu_en never high on consecutive cycles.
- Mid-operation reset: assert rst_n=0 during ISSUE with 3 entries queued -> outputs at reset values immediately; after release, occupancy=0 and no stale response.
